// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per cycle, valid/ready on both sides.
// Optional macro AES_ITER_CORE_KEY_CACHE_EN: reuse the stored decrypt schedule and skip KSCHED.

package aes_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[127-8*n -: 8] = inv ? isbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
    return r;
  endfunction

  // byte n = row (n%4), column (n/4)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*(inv ? (c+4-w)%4 : (c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return r;
  endfunction
endpackage

// Key expansion: holds a window of Nk words, emits 4 words per step and generates the next 4.
module aes_ks (
  input  logic         clk,
  input  logic         load,
  input  logic         next,
  input  logic [255:0] key,
  input  logic [1:0]   size,
  output logic [127:0] rk
);
  import aes_pkg::*;
  logic [31:0] win [8];
  logic [31:0] win_n [8];
  logic [31:0] ext [16];
  logic [31:0] t;
  logic [3:0]  m, m_n, nk, pos;
  logic [1:0]  size_q;
  logic [7:0]  rcon;
  logic        used_rc;

  assign nk = 4'd4 + {1'b0, size_q, 1'b0};
  assign m_n = (m + 4'd4 >= nk) ? m + 4'd4 - nk : m + 4'd4;
  assign rk = {win[0], win[1], win[2], win[3]};

  // m = index of the window's first word modulo Nk, which locates RotWord/SubWord positions
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = '0;
    for (int i = 0; i < 8; i++) if (4'(i) < nk) ext[i] = win[i];
    used_rc = 1'b0;
    t = '0;
    pos = '0;
    for (int j = 0; j < 4; j++) begin
      pos = m + 4'(j);
      t = ext[nk + 4'(j) - 4'd1];
      if (pos == 4'd0 || pos == nk) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        used_rc = 1'b1;
      end else if (nk == 4'd8 && pos == 4'd4) begin
        t = sub_word(t);
      end
      ext[nk + 4'(j)] = ext[j] ^ t;
    end
    for (int i = 0; i < 8; i++) win_n[i] = ext[i+4];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) win[i] <= key[255-32*i -: 32];
      m      <= '0;
      rcon   <= 8'h01;
      size_q <= size;
    end else if (next) begin
      for (int i = 0; i < 8; i++) win[i] <= win_n[i];
      m    <= m_n;
      rcon <= used_rc ? xt(rcon) : rcon;
    end
  end
endmodule

module aes_iter_core #(
  parameter int MAX_SIZE = 2,
  parameter int KS_DEPTH = 15,
  parameter int OUT_HOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [255:0] key_i,
  input  logic [127:0] data_i,
  input  logic [1:0]   size_i,
  input  logic         dec_i,
  input  logic         key_reuse_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         err_o
);
  import aes_pkg::*;
  typedef enum logic [1:0] {IDLE, KSCHED, DEC, DONE} state_t;
  state_t       state, state_n;
  logic [127:0] st, rk_q, ks_rk, sb, isb, enc_next, dec_next;
  logic [127:0] store [KS_DEPTH];
  logic [3:0]   round, round_max, nr_in;
  logic         dec_q, accept, bad_size, hit;

  assign accept   = in_valid_i & in_ready_o;
  assign bad_size = (size_i == 2'd3) || (int'(size_i) > MAX_SIZE);
  assign nr_in    = 4'd10 + {1'b0, size_i, 1'b0};

`ifdef AES_ITER_CORE_KEY_CACHE_EN
  logic       cache_valid;
  logic [1:0] cache_size, size_q;
  assign hit = key_reuse_i & cache_valid & dec_i & (size_i == cache_size);

  // Keys are not compared: any full schedule invalidates until a decrypt schedule completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_size  <= '0;
    end else if (accept && !bad_size && !hit) begin
      cache_valid <= 1'b0;
      size_q      <= size_i;
    end else if (state == KSCHED && dec_q && round == round_max) begin
      cache_valid <= 1'b1;
      cache_size  <= size_q;
    end
  end
`else
  logic unused_reuse;
  assign hit = 1'b0;
  assign unused_reuse = key_reuse_i;
`endif

  aes_ks u_ks (
    .clk  (clk),
    .load (accept & ~bad_size & ~hit),
    .next (state == KSCHED),
    .key  (key_i),
    .size (size_i),
    .rk   (ks_rk)
  );

  assign sb       = shift_rows(sub_bytes(st, 1'b0), 1'b0);
  assign enc_next = (round == 4'd0) ? st ^ ks_rk
                  : ((round == round_max) ? sb : mix_columns(sb)) ^ ks_rk;
  assign isb      = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk_q;
  assign dec_next = (round == round_max) ? st ^ rk_q
                  : (round == 4'd0) ? isb : inv_mix_columns(isb);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && !bad_size) state_n = hit ? DEC : KSCHED;
      KSCHED:  if (round == round_max) state_n = dec_q ? DEC : DONE;
      DEC:     if (round == 4'd0) state_n = DONE;
      DONE:    if (out_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == IDLE) & ~rst;
    out_valid_o = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round  <= '0;
      data_o <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= accept & bad_size;
      case (state)
        IDLE:   if (accept && !bad_size) round <= hit ? nr_in : 4'd0;
        KSCHED: if (round == round_max) begin
                  if (!dec_q) data_o <= enc_next;
                end else round <= round + 4'd1;
        DEC:    if (round == 4'd0) data_o <= dec_next;
                else round <= round - 4'd1;
        DONE:   if (out_ready_i && OUT_HOLD == 0) data_o <= '0;
        default: ;
      endcase
    end
  end

  // rk_q always holds the key for the next DEC round, so the store read never stalls.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (accept && !bad_size) begin
              st        <= data_i;
              dec_q     <= dec_i;
              round_max <= nr_in;
              if (hit) rk_q <= store[nr_in];
            end
      KSCHED: begin
        if (!dec_q) st <= enc_next;
        else store[round] <= ks_rk;
        if (dec_q && round == round_max) rk_q <= ks_rk;
      end
      DEC: begin
        st <= dec_next;
        if (round != 4'd0) rk_q <= store[round - 4'd1];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vectors for aes_iter_core: latency, hold, reject, reset-abandon and key-cache cases.
module tb_aes_iter_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_valid0, dec, key_reuse, out_ready;
  logic [255:0] key;
  logic [127:0] din, dout, dout0;
  logic [1:0]   size;
  logic         in_ready, out_valid, err, in_ready0, out_valid0, err0;
  int checks = 0, failures = 0;

  typedef struct {
    logic [255:0] key;
    logic [127:0] din;
    logic [1:0]   size;
    logic         dec;
    logic         reuse;
    logic [127:0] dout;
    int           lat;
    int           hold;
  } vec_t;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_iter_core dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .key_i(key),
    .data_i(din), .size_i(size), .dec_i(dec), .key_reuse_i(key_reuse),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout), .err_o(err));

  aes_iter_core #(.MAX_SIZE(0), .KS_DEPTH(11)) dut0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0), .key_i(key),
    .data_i(din), .size_i(size), .dec_i(dec), .key_reuse_i(key_reuse),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .data_o(dout0), .err_o(err0));

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    chk_i({name, " in_ready idle"}, int'(in_ready), 1);
    key = v.key; din = v.din; size = v.size; dec = v.dec; key_reuse = v.reuse; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; key = ~v.key; din = ~v.din; size = 2'd3; dec = ~v.dec;
    chk_i({name, " in_ready busy"}, int'(in_ready), 0);
    lat = -1;
    seen = 1'b0;
    for (int e = 0; e < 64 && !seen; e++) begin
      if (out_valid) begin
        seen = 1'b1;
        lat = e + 1;
      end else @(negedge clk);
    end
    chk_i({name, " latency"}, lat, v.lat);
    chk({name, " data"}, dout, v.dout);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({name, " hold data"}, dout, v.dout);
      chk_i({name, " hold valid/ready"}, int'({out_valid, in_ready}), 2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_i({name, " post-hs valid/ready"}, int'({out_valid, in_ready}), 1);
    chk({name, " post-hs data held"}, dout, v.dout);
  endtask

  vec_t vt [8];
  vec_t cv;
  bit   anyv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{key: K128, din: PT,   size: 2'd0, dec: 1'b0, reuse: 1'b0, dout: C128, lat: 12, hold: 0};
    vt[1] = '{key: K128, din: C128, size: 2'd0, dec: 1'b1, reuse: 1'b0, dout: PT,   lat: 23, hold: 0};
    vt[2] = '{key: K192, din: PT,   size: 2'd1, dec: 1'b0, reuse: 1'b0, dout: C192, lat: 14, hold: 0};
    vt[3] = '{key: K192, din: C192, size: 2'd1, dec: 1'b1, reuse: 1'b0, dout: PT,   lat: 27, hold: 0};
    vt[4] = '{key: K256, din: PT,   size: 2'd2, dec: 1'b0, reuse: 1'b0, dout: C256, lat: 16, hold: 5};
    vt[5] = '{key: K256, din: C256, size: 2'd2, dec: 1'b1, reuse: 1'b0, dout: PT,   lat: 31, hold: 0};
    vt[6] = '{key: KB,   din: PB,   size: 2'd0, dec: 1'b0, reuse: 1'b0, dout: CB,   lat: 12, hold: 0};
    vt[7] = '{key: KB,   din: CB,   size: 2'd0, dec: 1'b1, reuse: 1'b0, dout: PB,   lat: 23, hold: 2};

    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; dec = 1'b0; key_reuse = 1'b0;
    out_ready = 1'b0; key = '0; din = '0; size = '0;
    @(negedge clk);
    @(negedge clk);
    chk_i("reset in_ready", int'(in_ready), 0);
    chk_i("reset out_valid/err", int'({out_valid, err}), 0);
    chk("reset data_o", dout, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_i("in_ready after reset", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // unsupported size code 3
    @(negedge clk);
    size = 2'd3; dec = 1'b0; key = K256; din = PT; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_i("size3 err pulse", int'(err), 1);
    chk_i("size3 in_ready", int'(in_ready), 1);
    @(negedge clk);
    chk_i("size3 err one-shot", int'(err), 0);
    anyv = 1'b0;
    repeat (20) begin
      @(negedge clk);
      anyv |= out_valid;
    end
    chk_i("size3 no output", int'(anyv), 0);

    // size above MAX_SIZE on the 128-only instance
    size = 2'd1; in_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid0 = 1'b0;
    chk_i("max_size err pulse", int'(err0), 1);
    chk_i("max_size in_ready", int'(in_ready0), 1);
    @(negedge clk);
    chk_i("max_size err one-shot", int'(err0), 0);
    anyv = 1'b0;
    repeat (20) begin
      @(negedge clk);
      anyv |= out_valid0;
    end
    chk_i("max_size no output", int'(anyv), 0);

    // reset in the middle of a 256-bit decrypt schedule
    key = K256; din = C256; size = 2'd2; dec = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_i("mid-rst in_ready", int'(in_ready), 0);
    chk_i("mid-rst out_valid", int'(out_valid), 0);
    chk("mid-rst data_o", dout, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_i("after mid-rst in_ready/out_valid", int'({in_ready, out_valid}), 2);
    run_vec(vt[0], "post-rst enc128");

`ifdef AES_ITER_CORE_KEY_CACHE_EN
    run_vec(vt[1], "cache fill dec128");
    cv = vt[1]; cv.reuse = 1'b1; cv.lat = 12;
    run_vec(cv, "cache hit dec128");
    run_vec(vt[0], "cache kill enc128");
    cv.lat = 23;
    run_vec(cv, "cache miss dec128");
    cv = vt[3]; cv.reuse = 1'b1;
    run_vec(cv, "cache size miss dec192");
    cv.lat = 14;
    run_vec(cv, "cache hit dec192");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative, one-round-per-cycle AES engine supporting AES-128/192/256 encrypt and decrypt, with the round count taken from size_i.
- Valid/ready handshakes on both input and output replace the load/busy pulse interface.
- Uses aes_ks for the key schedule, with a round-key store for decryption.
- Sits between the command/DMA front end and the block-mode wrapper; one block in flight at a time.

Parameters:
MAX_SIZE, 2, highest accepted size code (0=128, 1=192, 2=256); requests above it are rejected with err_o.
KS_DEPTH, 15, round-key store entries; must be >= 11 + 2*MAX_SIZE.
OUT_HOLD, 1, 1 = data_o held after handshake until next result; 0 = data_o cleared to 0 on output handshake.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid_i  in  1  request valid
in_ready_o  out  1  core can accept request (high only in IDLE)
key_i  in  256  key, MSB-aligned: 128-bit key in [255:128], 192-bit in [255:64]
data_i  in  128  plaintext/ciphertext, FIPS-197 byte order (byte 0 = [127:120])
size_i  in  2  key size code
dec_i  in  1  1 = decrypt, 0 = encrypt
key_reuse_i  in  1  use cached schedule (only with AES_ITER_CORE_KEY_CACHE_EN)
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
data_o  out  128  result block
err_o  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset values: in_ready_o=0 during rst and 1 the cycle after; out_valid_o=0, data_o=0, err_o=0; FSM=IDLE; round=0; cache-valid flag cleared.
- Reset mid-operation abandons the block; no output is produced.
- Nr = 10/12/14 for size 0/1/2; round_max = Nr, latched at accept together with dec, size and data.
- FSM states: IDLE, KSCHED, DEC, DONE.
- IDLE: accept on in_valid_i & in_ready_o.
  - If size_i > MAX_SIZE or size_i == 3: pulse err_o next cycle, stay IDLE, assert no load to aes_ks.
  - Otherwise pulse load to aes_ks and go to KSCHED with round=0.
- KSCHED, one aes_ks key per cycle, round 0..Nr:
  - Encrypt: state <= state ^ ks at round 0; SubBytes/ShiftRows/MixColumns + key at 1..Nr-1; MixColumns skipped at Nr. After round Nr, capture into data_o and go to DONE. Latency from accept to out_valid_o = Nr+2 cycles (12/14/16).
  - Decrypt: write ks into store[round]. At round Nr go to DEC with round=Nr.
- DEC:
  - Inverse round using store[round]: round Nr is AddRoundKey only; rounds Nr-1..1 are InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns; round 0 is InvShiftRows/InvSubBytes/AddRoundKey.
  - Store read is registered one cycle ahead so no read-to-use hazard.
  - After round 0 go to DONE. Total decrypt latency = 2*(Nr+1)+1 cycles.
- DONE: out_valid_o=1 and data_o stable until out_ready_i. On handshake go to IDLE (in_ready_o=1 next cycle). No combinational path from out_ready_i to in_ready_o.
- in_valid_i while busy is ignored (in_ready_o=0); the upstream holds it.
- round counter is 4 bits, never wraps past Nr or below 0.
- All request fields are sampled only at accept; later changes on key_i/data_i have no effect.

Optional Feature:
Macro AES_ITER_CORE_KEY_CACHE_EN.
- Defined:
  - The core keeps a cache_valid flag plus the size of the last completed decrypt schedule.
  - On accept with key_reuse_i=1, cache_valid=1, dec_i=1 and size_i equal to the cached size, KSCHED is skipped: go straight to DEC, latency Nr+2.
  - key_reuse_i=1 with cache_valid=0 or a size mismatch performs a full schedule; no error.
  - Any encrypt, rst, or non-reuse request with a different key invalidates the cache. The core does not compare keys; the caller guarantees the key is unchanged.
- Undefined: key_reuse_i is ignored, no cache logic is built, and every request schedules fully.

Test Plan:
- AES-128 enc: key 000102..0f, pt 00112233445566778899aabbccddeeff -> data_o 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid_o 12 cycles after accept.
- AES-192 dec: key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff, out_valid_o 27 cycles after accept.
- AES-256 enc: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089. Hold out_ready_i=0 for 5 cycles: data_o stable, in_ready_o=0 throughout.
- size_i=3 -> err_o single pulse, no out_valid_o, in_ready_o high again. With MAX_SIZE=0 and size_i=1 -> same response.
- rst asserted mid-KSCHED of a 256 decrypt, then new AES-128 enc request -> correct 69c4e0d8... result, no stale output.
- AES_ITER_CORE_KEY_CACHE_EN: two back-to-back AES-128 decrypts with key_reuse_i=1 on the second -> both yield the plaintext; second latency 12 cycles. Encrypt between them forces a full 23-cycle schedule.
